// File: rtl/osd_uart16550_pkg.sv
// Register map constants and helpers shared by the 16550 register responder.
// Latency: none (constants and combinational helpers only); backpressure: n/a.
package osd_uart16550_pkg;

   typedef logic [2:0] reg_addr_t;

   localparam reg_addr_t RBR_THR = 3'd0;
   localparam reg_addr_t IER     = 3'd1;
   localparam reg_addr_t IIR_FCR = 3'd2;
   localparam reg_addr_t LCR     = 3'd3;
   localparam reg_addr_t MCR     = 3'd4;
   localparam reg_addr_t LSR     = 3'd5;
   localparam reg_addr_t MSR     = 3'd6;
   localparam reg_addr_t SCR     = 3'd7;

   localparam int LSR_DR   = 0;
   localparam int LSR_THRE = 5;
   localparam int LSR_TEMT = 6;

   localparam logic [7:0] IIR_NONE = 8'hC1;
   localparam logic [7:0] IIR_THRE = 8'hC2;
   localparam logic [7:0] IIR_RDA  = 8'hC4;

   localparam logic [7:0] MSR_VAL  = 8'hB0;

   function automatic logic [7:0] lsr_pack(input logic dr, input logic tx_empty);
      logic [7:0] v;
      v           = '0;
      v[LSR_DR]   = dr;
      v[LSR_THRE] = tx_empty;
      v[LSR_TEMT] = tx_empty;
      return v;
   endfunction

endpackage

// File: rtl/osd_uart16550_fifo.sv
// Synchronous 8-bit FIFO with clear; data written on one edge is visible at the head the next cycle.
// Backpressure: in_rdy drops when full, out_vld drops when empty; clear beats a same-cycle push.
module osd_uart16550_fifo #(
   parameter int DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       in_vld,
   output logic       in_rdy,
   input  logic [7:0] in_dat,
   output logic       out_vld,
   input  logic       out_rdy,
   output logic [7:0] out_dat
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;

   assign in_rdy  = (count != FULL_CNT);
   assign out_vld = (count != '0);
   assign out_dat = mem[rd_ptr];
   assign push    = in_vld && in_rdy;
   assign pop     = out_rdy && out_vld;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= in_dat;
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/osd_uart16550_regs.sv
// 16550 register responder: THR writes feed the TX stream, RBR reads drain the RX stream; R and B answer 1 cycle after the handshake.
// Backpressure: writes stall while the B slot is held or a THR write meets a full TX FIFO; reads stall while R is held.
module osd_uart16550_regs
   import osd_uart16550_pkg::*;
#(
   parameter int TX_DEPTH = 16,
   parameter int RX_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  ar_addr,
   input  logic        ar_valid,
   output logic        ar_ready,
   output logic [7:0]  r_data,
   output logic [1:0]  r_resp,
   output logic        r_valid,
   input  logic        r_ready,
   input  logic [2:0]  aw_addr,
   input  logic        aw_valid,
   output logic        aw_ready,
   input  logic [7:0]  w_data,
   input  logic        w_valid,
   output logic        w_ready,
   output logic [1:0]  b_resp,
   output logic        b_valid,
   input  logic        b_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [15:0] divisor,
   output logic        irq
);

   logic [7:0] lcr, scr, dll, dlm;
   logic [3:0] ier;
   logic [4:0] mcr;
   logic       dlab;
   logic       thr_sel, wr_rdy, wr_fire, ar_fire;
   logic       tx_in_rdy, tx_clr, rx_clr;
   logic       rx_out_vld, rx_out_rdy;
   logic [7:0] rx_out_dat;
   logic [7:0] iir, rd_dat;

   assign dlab    = lcr[7];
   assign divisor = {dlm, dll};
   assign r_resp  = 2'b00;
   assign b_resp  = 2'b00;

   // The B slot frees in the same cycle b_ready takes it, so writes can stream one per cycle.
   assign thr_sel  = (aw_addr == RBR_THR) && !dlab;
   assign wr_rdy   = (!b_valid || b_ready) && !(thr_sel && !tx_in_rdy);
   assign aw_ready = wr_rdy;
   assign w_ready  = wr_rdy;
   assign wr_fire  = aw_valid && w_valid && wr_rdy;
   assign tx_clr   = wr_fire && (aw_addr == IIR_FCR) && w_data[2];
   assign rx_clr   = wr_fire && (aw_addr == IIR_FCR) && w_data[1];

   assign ar_ready   = !r_valid || r_ready;
   assign ar_fire    = ar_valid && ar_ready;
   assign rx_out_rdy = ar_fire && (ar_addr == RBR_THR) && !dlab;

   osd_uart16550_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .clr     (tx_clr),
      .in_vld  (wr_fire && thr_sel),
      .in_rdy  (tx_in_rdy),
      .in_dat  (w_data),
      .out_vld (tx_valid),
      .out_rdy (tx_ready),
      .out_dat (tx_data)
   );

   osd_uart16550_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .rst     (rst),
      .clr     (rx_clr),
      .in_vld  (rx_valid),
      .in_rdy  (rx_ready),
      .in_dat  (rx_data),
      .out_vld (rx_out_vld),
      .out_rdy (rx_out_rdy),
      .out_dat (rx_out_dat)
   );

   always_comb begin
      iir = IIR_NONE;
      if (rx_out_vld && ier[0])
         iir = IIR_RDA;
      else if (!tx_valid && ier[1])
         iir = IIR_THRE;
   end

   // Read data comes from pre-write state; a concurrent write lands on the same edge.
   always_comb begin
      rd_dat = '0;
      case (ar_addr)
         RBR_THR: rd_dat = dlab ? dll : (rx_out_vld ? rx_out_dat : 8'h00);
         IER:     rd_dat = dlab ? dlm : {4'b0, ier};
         IIR_FCR: rd_dat = iir;
         LCR:     rd_dat = lcr;
         MCR:     rd_dat = {3'b0, mcr};
         LSR:     rd_dat = lsr_pack(rx_out_vld, !tx_valid);
         MSR:     rd_dat = MSR_VAL;
         SCR:     rd_dat = scr;
         default: rd_dat = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lcr     <= '0;
         ier     <= '0;
         mcr     <= '0;
         scr     <= '0;
         dll     <= '0;
         dlm     <= '0;
         b_valid <= 1'b0;
         r_valid <= 1'b0;
         r_data  <= '0;
         irq     <= 1'b0;
      end else begin
         if (wr_fire) begin
            case (aw_addr)
               RBR_THR: if (dlab) dll <= w_data;
               IER:     if (dlab) dlm <= w_data; else ier <= w_data[3:0];
               LCR:     lcr <= w_data;
               MCR:     mcr <= w_data[4:0];
               SCR:     scr <= w_data;
               default: ;
            endcase
         end
         if (wr_fire)
            b_valid <= 1'b1;
         else if (b_ready)
            b_valid <= 1'b0;
         if (ar_fire) begin
            r_valid <= 1'b1;
            r_data  <= rd_dat;
         end else if (r_ready) begin
            r_valid <= 1'b0;
         end
         irq <= (iir != IIR_NONE);
      end
   end

endmodule

// File: tb/tb_osd_uart16550_regs.sv
// Directed bench for osd_uart16550_regs: bus register accesses, TX/RX streams, IRQ and reset.
module tb_osd_uart16550_regs;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  ar_addr = '0;
   logic        ar_valid = 1'b0;
   logic        ar_ready;
   logic [7:0]  r_data;
   logic [1:0]  r_resp;
   logic        r_valid;
   logic        r_ready = 1'b1;
   logic [2:0]  aw_addr = '0;
   logic        aw_valid = 1'b0;
   logic        aw_ready;
   logic [7:0]  w_data = '0;
   logic        w_valid = 1'b0;
   logic        w_ready;
   logic [1:0]  b_resp;
   logic        b_valid;
   logic        b_ready = 1'b1;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [15:0] divisor;
   logic        irq;

   int n_chk = 0;
   int n_pass = 0;
   int stall_cycles = 0;
   logic [7:0] rd;
   logic [7:0] hello [13] = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h20, 8'h57,
                              8'h6f, 8'h72, 8'h6c, 8'h64, 8'h21, 8'h0a};

   osd_uart16550_regs dut (
      .clk(clk), .rst(rst),
      .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
      .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
      .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
      .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
      .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .divisor(divisor), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Called at a falling edge; returns at the falling edge after the write handshake.
   task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
      int t;
      t = 0;
      aw_addr = a; w_data = d; aw_valid = 1'b1; w_valid = 1'b1;
      #1;
      while (!(aw_ready && w_ready) && t < 50) begin
         @(negedge clk); #1;
         t++;
         stall_cycles++;
      end
      chk("aw_handshake", {aw_ready, w_ready}, 2'b11);
      @(posedge clk);
      @(negedge clk);
      aw_valid = 1'b0; w_valid = 1'b0;
      chk("b_okay", {b_valid, b_resp}, 3'b100);
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
      int t;
      t = 0;
      ar_addr = a; ar_valid = 1'b1;
      #1;
      while (!ar_ready && t < 50) begin
         @(negedge clk); #1;
         t++;
      end
      chk("ar_handshake", ar_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      ar_valid = 1'b0;
      chk("r_okay", {r_valid, r_resp}, 3'b100);
      d = r_data;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_outs", {r_valid, b_valid, tx_valid, rx_ready, irq}, 5'b00010);
      chk("rst_div", divisor, 16'h0000);

      bus_read(3'd5, rd); chk("lsr_reset", rd, 8'h60);
      bus_read(3'd2, rd); chk("iir_reset", rd, 8'hc1);
      bus_read(3'd6, rd); chk("msr", rd, 8'hb0);

      bus_write(3'd3, 8'h80);
      bus_write(3'd0, 8'hde);
      bus_write(3'd1, 8'had);
      chk("div_dlab", divisor, 16'hadde);
      bus_read(3'd0, rd); chk("dll_rd", rd, 8'hde);
      bus_write(3'd3, 8'h00);
      chk("div_final", divisor, 16'hadde);
      chk("div_no_tx", tx_valid, 1'b0);
      bus_read(3'd0, rd); chk("rbr_empty", rd, 8'h00);

      bus_write(3'd7, 8'h3c); bus_read(3'd7, rd); chk("scr_rw", rd, 8'h3c);
      bus_write(3'd4, 8'hff); bus_read(3'd4, rd); chk("mcr_mask", rd, 8'h1f);
      bus_write(3'd3, 8'h1b); bus_read(3'd3, rd); chk("lcr_rw", rd, 8'h1b);
      bus_write(3'd3, 8'h00);
      bus_write(3'd6, 8'h00); bus_read(3'd6, rd); chk("msr_ro", rd, 8'hb0);
      bus_write(3'd5, 8'hff); bus_read(3'd5, rd); chk("lsr_ro", rd, 8'h60);

      tx_ready = 1'b0;
      stall_cycles = 0;
      for (int i = 0; i < 13; i++) bus_write(3'd0, hello[i]);
      chk("hello_stalls", 16'(stall_cycles), 16'd0);
      bus_read(3'd5, rd); chk("hello_lsr_busy", rd, 8'h00);
      tx_ready = 1'b1;
      for (int i = 0; i < 13; i++) begin
         chk("hello_vld", tx_valid, 1'b1);
         chk("hello_byte", tx_data, hello[i]);
         @(negedge clk);
      end
      tx_ready = 1'b0;
      chk("hello_drained", tx_valid, 1'b0);
      bus_read(3'd5, rd); chk("hello_lsr_idle", rd, 8'h60);

      stall_cycles = 0;
      for (int i = 0; i < 16; i++) bus_write(3'd0, 8'(8'h10 + i));
      chk("fill_stalls", 16'(stall_cycles), 16'd0);
      aw_addr = 3'd0; w_data = 8'h99; aw_valid = 1'b1; w_valid = 1'b1;
      #1;
      chk("full_wrdy", w_ready, 1'b0);
      @(negedge clk); #1;
      chk("full_awrdy", aw_ready, 1'b0);
      chk("full_head", tx_data, 8'h10);
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      #1;
      chk("full_accept", {aw_ready, w_ready}, 2'b11);
      @(posedge clk);
      @(negedge clk);
      aw_valid = 1'b0; w_valid = 1'b0;
      chk("full_b", b_valid, 1'b1);
      tx_ready = 1'b1;
      for (int i = 1; i < 16; i++) begin
         chk("full_byte", tx_data, 16'(8'h10 + i));
         @(negedge clk);
      end
      chk("full_last", tx_data, 8'h99);
      @(negedge clk);
      tx_ready = 1'b0;
      chk("full_drained", tx_valid, 1'b0);

      bus_write(3'd1, 8'h01);
      chk("irq_idle", irq, 1'b0);
      rx_data = 8'h5a; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      @(negedge clk);
      chk("irq_rx", irq, 1'b1);
      bus_read(3'd2, rd); chk("iir_rda", rd, 8'hc4);
      bus_read(3'd0, rd); chk("rbr_data", rd, 8'h5a);
      chk("irq_lag", irq, 1'b1);
      @(negedge clk);
      chk("irq_clear", irq, 1'b0);
      bus_read(3'd5, rd); chk("lsr_dr0", rd, 8'h60);
      bus_read(3'd0, rd); chk("rbr_again", rd, 8'h00);

      bus_write(3'd1, 8'hf2);
      bus_read(3'd1, rd); chk("ier_mask", rd, 8'h02);
      bus_read(3'd2, rd); chk("iir_thre", rd, 8'hc2);
      chk("irq_thre", irq, 1'b1);

      for (int i = 0; i < 16; i++) begin
         rx_data = 8'(i); rx_valid = 1'b1;
         @(negedge clk);
      end
      rx_valid = 1'b0;
      chk("rx_full", rx_ready, 1'b0);
      bus_read(3'd5, rd); chk("lsr_rx_full", rd, 8'h61);
      bus_read(3'd2, rd); chk("iir_rda_masked", rd, 8'hc2);
      bus_write(3'd0, 8'h77);
      chk("tx_one", tx_valid, 1'b1);
      bus_write(3'd2, 8'h06);
      chk("fcr_clear", {tx_valid, rx_ready}, 2'b01);
      bus_read(3'd5, rd); chk("lsr_cleared", rd, 8'h60);
      bus_write(3'd1, 8'h00);

      r_ready = 1'b0;
      bus_read(3'd6, rd); chk("r_first", rd, 8'hb0);
      chk("r_hold_ar", ar_ready, 1'b0);
      @(negedge clk);
      chk("r_hold", {r_valid, r_data}, 9'h1b0);
      r_ready = 1'b1;
      @(negedge clk);
      chk("r_drop", r_valid, 1'b0);

      b_ready = 1'b0;
      bus_write(3'd7, 8'h55);
      aw_addr = 3'd7; w_data = 8'haa; aw_valid = 1'b1; w_valid = 1'b1;
      #1;
      chk("bp_rdy", {aw_ready, w_ready}, 2'b00);
      @(negedge clk); #1;
      chk("bp_hold", {b_valid, aw_ready, w_ready}, 3'b100);
      rst = 1'b1; aw_valid = 1'b0; w_valid = 1'b0;
      @(negedge clk);
      chk("rst2_outs", {b_valid, r_valid, tx_valid, rx_ready, irq}, 5'b00010);
      chk("rst2_div", divisor, 16'h0000);
      rst = 1'b0; b_ready = 1'b1;
      bus_read(3'd7, rd); chk("rst2_scr", rd, 8'h00);
      bus_read(3'd3, rd); chk("rst2_lcr", rd, 8'h00);
      bus_read(3'd1, rd); chk("rst2_ier", rd, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
